// File: rtl/timer_ctrl_8b.sv
// Programmable 8-bit timer: prescaled up-counter with terminal-count compare,
// start/pause/stop control, one-shot or periodic reload and a one-cycle done pulse.
`timescale 1ns/1ps
module timer_ctrl_8b #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  stop_i,
  input  logic                  periodic_i,
  input  logic [7:0]            term_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [7:0]            count_o,
  output logic                  busy_o,
  output logic                  paused_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t                  state_q;
  logic [7:0]              term_q;
  logic [PRESCALE_W-1:0]   psc_q;
  logic                    per_q;
  logic [PRESCALE_W-1:0]   psc_cnt_q;
  logic [7:0]              count_q;
  logic                    busy_q;
  logic                    paused_q;
  logic                    done_q;
  logic                    en;

  assign en = (state_q == RUN) && (psc_cnt_q == psc_q);

  // Priority within a cycle: reset, stop, pause, start, then the tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      term_q    <= '0;
      psc_q     <= '0;
      per_q     <= 1'b0;
      psc_cnt_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q   <= IDLE;
        psc_cnt_q <= '0;
        count_q   <= '0;
        busy_q    <= 1'b0;
        paused_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              term_q    <= term_i;
              psc_q     <= prescale_i;
              per_q     <= periodic_i;
              psc_cnt_q <= '0;
              count_q   <= '0;
              state_q   <= RUN;
              busy_q    <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          RUN: begin
            if (pause_i) begin
              state_q  <= PAUSED;
              paused_q <= 1'b1;
            end else if (en) begin
              psc_cnt_q <= '0;
              if (count_q == term_q) begin
                done_q <= 1'b1;
                // One-shot parks in IDLE with the final count still visible.
                if (per_q) begin
                  count_q <= '0;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                count_q <= count_q + 8'd1;
              end
            end else begin
              psc_cnt_q <= psc_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
          end
          PAUSED: begin
            if (start_i) begin
              state_q  <= RUN;
              paused_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_o  = count_q;
  assign busy_o   = busy_q;
  assign paused_o = paused_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_timer_ctrl_8b.sv
// Directed-vector bench for timer_ctrl_8b; inputs change 1ns after a rising edge,
// outputs are checked at that same point for the edge just taken.
`timescale 1ns/1ps
module tb_timer_ctrl_8b;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       stop;
  logic       periodic;
  logic [7:0] term;
  logic [7:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       paused;
  logic       done;

  int testsRun;
  int testsFailed;

  timer_ctrl_8b #(.PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .pause_i    (pause),
    .stop_i     (stop),
    .periodic_i (periodic),
    .term_i     (term),
    .prescale_i (prescale),
    .count_o    (count),
    .busy_o     (busy),
    .paused_o   (paused),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic pa, input logic sp,
                               input logic per, input logic [7:0] t, input logic [7:0] p);
    start    = st;
    pause    = pa;
    stop     = sp;
    periodic = per;
    term     = t;
    prescale = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic releaseInputs();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic doStop();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    step();
    releaseInputs();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step();
    step();
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_flags", 32'({busy, paused, done}), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("idle_quiet", 32'({count, busy, paused, done}), 32'd0);
    end

    // One-shot T=5 P=0: count 1..5 at E0+1..5, done after E0+6
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0);
    step();
    releaseInputs();
    checkOutput("os_busy_e0", 32'(busy), 32'd1);
    checkOutput("os_count_e0", 32'(count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput("os_count", 32'(count), 32'(k));
      checkOutput("os_done_early", 32'(done), 32'd0);
    end
    step();
    checkOutput("os_done", 32'(done), 32'd1);
    checkOutput("os_busy_fall", 32'(busy), 32'd0);
    checkOutput("os_count_hold", 32'(count), 32'd5);
    step();
    checkOutput("os_done_once", 32'(done), 32'd0);
    checkOutput("os_count_hold2", 32'(count), 32'd5);
    doStop();
    checkOutput("os_stop_clear", 32'(count), 32'd0);

    // Periodic T=3 P=2: done every 12 clocks, count held 3 clocks per value
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd2);
    step();
    releaseInputs();
    for (int c = 1; c <= 60; c++) begin
      step();
      checkOutput("per_done", 32'(done), (c % 12 == 0) ? 32'd1 : 32'd0);
      checkOutput("per_count", 32'(count), 32'((c / 3) % 4));
    end
    checkOutput("per_busy", 32'(busy), 32'd1);
    doStop();
    checkOutput("per_stop_busy", 32'(busy), 32'd0);

    // Pause at count=4 for 7 lost edges, T=9 P=0: done at E0+17 instead of E0+10
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
    step();
    releaseInputs();
    for (int c = 1; c <= 4; c++) step();
    checkOutput("pz_count_before", 32'(count), 32'd4);
    pause = 1'b1;
    step();
    pause = 1'b0;
    for (int c = 5; c <= 10; c++) begin
      if (c > 5) step();
      checkOutput("pz_paused", 32'(paused), 32'd1);
      checkOutput("pz_frozen", 32'(count), 32'd4);
      checkOutput("pz_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("pz_resume", 32'(paused), 32'd0);
    checkOutput("pz_resume_count", 32'(count), 32'd4);
    for (int c = 12; c <= 16; c++) begin
      step();
      checkOutput("pz_count", 32'(count), 32'(c - 7));
      checkOutput("pz_no_done", 32'(done), 32'd0);
    end
    step();
    checkOutput("pz_done", 32'(done), 32'd1);
    checkOutput("pz_done_busy", 32'(busy), 32'd0);
    doStop();

    // Stop on the terminal cycle suppresses done
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0);
    step();
    releaseInputs();
    step();
    step();
    checkOutput("st_count", 32'(count), 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("st_no_done", 32'(done), 32'd0);
    checkOutput("st_count0", 32'(count), 32'd0);
    checkOutput("st_idle", 32'(busy), 32'd0);
    step();
    checkOutput("st_no_done2", 32'(done), 32'd0);

    // stop+start together in IDLE stays IDLE
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 8'd0);
    step();
    releaseInputs();
    checkOutput("stst_idle", 32'(busy), 32'd0);

    // pause+start together in RUN goes to PAUSED
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd50, 8'd0);
    step();
    releaseInputs();
    step();
    step();
    start = 1'b1;
    pause = 1'b1;
    step();
    releaseInputs();
    checkOutput("pzst_paused", 32'(paused), 32'd1);
    checkOutput("pzst_count", 32'(count), 32'd2);
    doStop();
    checkOutput("pzst_stop", 32'({busy, paused}), 32'd0);

    // T=0 P=0 periodic: done every cycle from E0+1, count stays 0
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    step();
    releaseInputs();
    checkOutput("t0_done_e0", 32'(done), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      checkOutput("t0_done", 32'(done), 32'd1);
      checkOutput("t0_count", 32'(count), 32'd0);
    end
    doStop();

    // Inputs changed mid-run are ignored: T=3 P=0 one-shot ends at E0+4
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd100, 8'd7);
    step();
    step();
    step();
    checkOutput("chg_count", 32'(count), 32'd3);
    step();
    checkOutput("chg_done", 32'(done), 32'd1);
    checkOutput("chg_busy", 32'(busy), 32'd0);
    doStop();

    // Reset mid-run
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 8'd0);
    step();
    releaseInputs();
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("rst_mid", 32'({count, busy, paused, done}), 32'd0);

    // Reset on the terminal edge discards done
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0);
    step();
    releaseInputs();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("rst_term_done", 32'(done), 32'd0);
    step();
    checkOutput("rst_term_done2", 32'(done), 32'd0);
    checkOutput("rst_term_busy", 32'(busy), 32'd0);

    // T=255 P=255 one-shot: terminal edge at E0+65536
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 8'd255);
    step();
    releaseInputs();
    for (int c = 1; c <= 65535; c++) begin
      step();
      if (c == 255) checkOutput("big_count_1", 32'(count), 32'd0);
      if (c == 256) checkOutput("big_count_2", 32'(count), 32'd1);
      if (done) checkOutput("big_early_done", 32'(c), 32'd65536);
    end
    checkOutput("big_count_max", 32'(count), 32'd255);
    checkOutput("big_busy", 32'(busy), 32'd1);
    step();
    checkOutput("big_done", 32'(done), 32'd1);
    checkOutput("big_busy_fall", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
